// File: rtl/cpu_pkg.sv
// Shared types and constants for the core front end.
package cpu_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSN_W  = 32;
    localparam int PC_INCR = 4;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle of the fetch unit: imem request/response, redirect from execute
// and the decode handshake.
//
// Handshake rule for both valid/ready channels (imem request, decode):
// a transfer happens on a rising clock edge where valid and ready are both 1.
// The sender keeps valid and its payload stable until the transfer, except
// that the fetch unit may drop or retarget its imem request on a redirect
// cycle. The imem response channel has no ready: a valid response is always
// taken, and responses come back in request order.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [INSN_W-1:0] imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              dec_valid;
    logic              dec_ready;
    logic [ADDR_W-1:0] dec_pc;
    logic [INSN_W-1:0] dec_instruction;

    // Fetch unit side.
    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output dec_valid,
        input  dec_ready,
        output dec_pc,
        output dec_instruction
    );

    // Environment side: instruction memory, execute and decode.
    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  dec_valid,
        output dec_ready,
        input  dec_pc,
        input  dec_instruction
    );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched instructions. Flush wins over push and
// pop on the same edge. The head is read straight out of the storage
// registers, so a pushed entry becomes visible one cycle after the push.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_entry,
    output fetch_entry_t     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: generates the PC, issues word fetches to
// instruction memory, queues in-order responses and hands {pc, instruction}
// to decode. A redirect from execute flushes the queue and marks every
// still-unanswered request as stale so its response is dropped.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                DEPTH           = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
    input logic          clock,
    input logic          reset_n,
    fetch_unit_if.master bus
);

    localparam int IF_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [IF_W-1:0]   inflight;
    logic [IF_W-1:0]   inflight_next;
    logic [IF_W-1:0]   drop;
    logic [IF_W-1:0]   live;
    logic              req_valid;
    logic              req_fire;

    logic              q_push;
    logic              q_pop;
    logic              q_flush;
    logic              q_full;
    logic              q_empty;
    logic [CNT_W-1:0]  q_count;
    fetch_entry_t      q_in;
    fetch_entry_t      q_head;

    // Requests still owed a response that will actually land in the queue.
    assign live = inflight - drop;

    // Issue only if the queue is guaranteed room for every live response.
    // Gated by reset_n so the request drops the moment reset is asserted.
    always_comb begin
        req_valid = 1'b0;
        if (reset_n && !bus.redirect_valid && !q_full
            && (inflight < IF_W'(MAX_OUTSTANDING))
            && ((32'(q_count) + 32'(live)) < 32'(DEPTH))) begin
            req_valid = 1'b1;
        end
    end

    assign req_fire           = req_valid && bus.imem_req_ready;
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;

    // Outstanding count after this edge: one more per accepted request,
    // one less per response (stale or not).
    always_comb begin
        inflight_next = inflight;
        case ({req_fire, bus.imem_rsp_valid})
            2'b10:   inflight_next = inflight + IF_W'(1);
            2'b01:   inflight_next = inflight - IF_W'(1);
            default: inflight_next = inflight;
        endcase
    end

    // Fresh responses go to the queue; stale ones and redirect-cycle ones do not.
    assign q_push  = bus.imem_rsp_valid && (drop == '0) && !bus.redirect_valid;
    assign q_pop   = bus.dec_valid && bus.dec_ready;
    assign q_flush = bus.redirect_valid;
    assign q_in    = '{pc: rsp_pc, instruction: bus.imem_rsp_data};

    // PC, response PC and credit bookkeeping; redirect overrides everything.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight_next;
            if (bus.redirect_valid) begin
                fetch_pc <= bus.redirect_pc;
                rsp_pc   <= bus.redirect_pc;
                drop     <= inflight_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + ADDR_W'(PC_INCR);
                end
                if (bus.imem_rsp_valid) begin
                    if (drop != '0) begin
                        drop <= drop - IF_W'(1);
                    end else begin
                        rsp_pc <= rsp_pc + ADDR_W'(PC_INCR);
                    end
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (q_push),
        .pop       (q_pop),
        .flush     (q_flush),
        .push_entry(q_in),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign bus.dec_valid       = !q_empty;
    assign bus.dec_pc          = q_head.pc;
    assign bus.dec_instruction = q_head.instruction;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model of
// configurable latency and a decode-side monitor.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    fetch_unit_if bus ();

    fetch_unit #(
        .DEPTH          (4),
        .MAX_OUTSTANDING(2),
        .RESET_PC       (64'h0)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int mem_lat = 1;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [63:0] obs_pc[$];
    logic [31:0] obs_insn[$];

    // Memory content: every word is a recognisable function of its address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'hD500_0000 ^ a[31:0];
    endfunction

    // One clock cycle: mid-cycle sampling (memory capture, decode monitor,
    // overflow watch), then the edge, then drive the memory response.
    task automatic tick();
        pend_t p;
        @(negedge clock);
        if (!reset_n) begin
            pend_q.delete();
        end else begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                p.addr = bus.imem_req_addr;
                p.due  = cyc + 1 + mem_lat;
                pend_q.push_back(p);
            end
            if (bus.dec_valid && bus.dec_ready && !bus.redirect_valid) begin
                obs_pc.push_back(bus.dec_pc);
                obs_insn.push_back(bus.dec_instruction);
            end
            if (dut.q_push && dut.q_full) begin
                errors++;
                $display("FAIL overflow: push while queue full at cycle %0d", cyc);
            end
        end
        @(posedge clock);
        cyc++;
        #1;
        if (reset_n && pend_q.size() > 0 && pend_q[0].due == cyc + 1) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend_q[0].addr);
            void'(pend_q.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
    endtask

    // Hold reset for two cycles, then release just after a rising edge.
    task automatic do_reset(input int lat, input logic rdy);
        reset_n            = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.dec_ready      = rdy;
        bus.imem_req_ready = 1'b1;
        mem_lat            = lat;
        repeat (2) tick();
        reset_n = 1'b1;
        obs_pc.delete();
        obs_insn.delete();
    endtask

    task automatic test_reset();
        reset_n            = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.dec_ready      = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        repeat (2) tick();
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid);
        end
        checks++;
        if (bus.dec_valid !== 1'b0) begin
            errors++; $display("FAIL reset_dec_valid: got %b expected 0", bus.dec_valid);
        end
        checks++;
        if (bus.dec_pc !== 64'h0) begin
            errors++; $display("FAIL reset_dec_pc: got %h expected 0", bus.dec_pc);
        end
        checks++;
        if (bus.dec_instruction !== 32'h0) begin
            errors++; $display("FAIL reset_dec_insn: got %h expected 0", bus.dec_instruction);
        end
        checks++;
        if (bus.imem_req_addr !== 64'h0) begin
            errors++; $display("FAIL reset_req_addr: got %h expected 0", bus.imem_req_addr);
        end
    endtask

    // 1-cycle memory, decoder always ready: first instruction after edge 2,
    // then one per cycle.
    task automatic test_stream();
        do_reset(1, 1'b1);
        tick();
        checks++;
        if (bus.dec_valid !== 1'b0) begin
            errors++; $display("FAIL stream_early_valid: got %b expected 0", bus.dec_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 64'(4 * i)
                || bus.dec_instruction !== mem_word(64'(4 * i))) begin
                errors++;
                $display("FAIL stream_head%0d: got v=%b pc=%h insn=%h expected v=1 pc=%h insn=%h",
                         i, bus.dec_valid, bus.dec_pc, bus.dec_instruction,
                         64'(4 * i), mem_word(64'(4 * i)));
            end
        end
    endtask

    // Decoder stalled: the queue fills to exactly four and fetch stops.
    task automatic test_stall();
        logic [63:0] exp_pc [5];
        exp_pc = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10};
        do_reset(1, 1'b0);
        repeat (20) tick();
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL stall_req_valid: got %b expected 0", bus.imem_req_valid);
        end
        checks++;
        if (bus.imem_req_addr !== 64'h10) begin
            errors++; $display("FAIL stall_req_addr: got %h expected 10", bus.imem_req_addr);
        end
        checks++;
        if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 64'h0) begin
            errors++; $display("FAIL stall_head: got v=%b pc=%h expected v=1 pc=0", bus.dec_valid, bus.dec_pc);
        end
        bus.dec_ready = 1'b1;
        repeat (10) tick();
        checks++;
        if (obs_pc.size() < 5) begin
            errors++; $display("FAIL stall_drain_count: got %0d expected >=5", obs_pc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs_pc[i] !== exp_pc[i] || obs_insn[i] !== mem_word(exp_pc[i])) begin
                    errors++;
                    $display("FAIL stall_drain%0d: got pc=%h insn=%h expected pc=%h insn=%h",
                             i, obs_pc[i], obs_insn[i], exp_pc[i], mem_word(exp_pc[i]));
                end
            end
        end
    endtask

    // 3-cycle memory with two requests in flight, then redirect to 0x400.
    task automatic test_redirect_latency();
        do_reset(3, 1'b1);
        repeat (2) tick();
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL lat_credit_stop: got %b expected 0", bus.imem_req_valid);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h400;
        tick();
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.dec_valid !== 1'b0) begin
            errors++; $display("FAIL lat_flush_valid: got %b expected 0", bus.dec_valid);
        end
        checks++;
        if (bus.imem_req_addr !== 64'h400) begin
            errors++; $display("FAIL lat_new_addr: got %h expected 400", bus.imem_req_addr);
        end
        repeat (12) tick();
        checks++;
        if (obs_pc.size() < 2) begin
            errors++; $display("FAIL lat_delivered: got %0d entries expected >=2", obs_pc.size());
        end else begin
            checks++;
            if (obs_pc[0] !== 64'h400 || obs_insn[0] !== mem_word(64'h400)) begin
                errors++; $display("FAIL lat_first: got pc=%h insn=%h expected pc=400 insn=%h",
                                   obs_pc[0], obs_insn[0], mem_word(64'h400));
            end
            checks++;
            if (obs_pc[1] !== 64'h404) begin
                errors++; $display("FAIL lat_second: got pc=%h expected 404", obs_pc[1]);
            end
        end
    endtask

    // Redirect lands together with a response and a decode pop.
    task automatic test_redirect_collision();
        do_reset(1, 1'b1);
        repeat (2) tick();
        checks++;
        if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 64'h0) begin
            errors++; $display("FAIL coll_pre: got v=%b pc=%h expected v=1 pc=0", bus.dec_valid, bus.dec_pc);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h400;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL coll_req_forced: got %b expected 0", bus.imem_req_valid);
        end
        tick();
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.dec_valid !== 1'b0 || bus.imem_req_addr !== 64'h400) begin
            errors++; $display("FAIL coll_after: got v=%b addr=%h expected v=0 addr=400",
                               bus.dec_valid, bus.imem_req_addr);
        end
        tick();
        checks++;
        if (bus.dec_valid !== 1'b0) begin
            errors++; $display("FAIL coll_gap: got %b expected 0", bus.dec_valid);
        end
        tick();
        checks++;
        if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 64'h400 || bus.dec_instruction !== mem_word(64'h400)) begin
            errors++; $display("FAIL coll_target: got v=%b pc=%h insn=%h expected v=1 pc=400 insn=%h",
                               bus.dec_valid, bus.dec_pc, bus.dec_instruction, mem_word(64'h400));
        end
        tick();
        checks++;
        if (bus.dec_pc !== 64'h404) begin
            errors++; $display("FAIL coll_next: got %h expected 404", bus.dec_pc);
        end
    endtask

    // Two redirects on consecutive cycles: only the second target is fetched.
    task automatic test_back_to_back_redirect();
        int bad;
        do_reset(1, 1'b1);
        repeat (4) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h100;
        obs_pc.delete();
        obs_insn.delete();
        tick();
        bus.redirect_pc = 64'h200;
        tick();
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.imem_req_addr !== 64'h200) begin
            errors++; $display("FAIL b2b_addr: got %h expected 200", bus.imem_req_addr);
        end
        repeat (8) tick();
        bad = 0;
        foreach (obs_pc[i]) begin
            if (obs_pc[i] >= 64'h100 && obs_pc[i] < 64'h200) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL b2b_stale: got %0d entries from 0x100 expected 0", bad);
        end
        checks++;
        if (obs_pc.size() < 2) begin
            errors++; $display("FAIL b2b_count: got %0d expected >=2", obs_pc.size());
        end else begin
            checks++;
            if (obs_pc[0] !== 64'h200 || obs_pc[1] !== 64'h204) begin
                errors++; $display("FAIL b2b_order: got %h,%h expected 200,204", obs_pc[0], obs_pc[1]);
            end
        end
    endtask

    // Asynchronous reset with the queue half full.
    task automatic test_reset_midstream();
        do_reset(1, 1'b0);
        repeat (3) tick();
        checks++;
        if (bus.dec_valid !== 1'b1) begin
            errors++; $display("FAIL mid_pre_valid: got %b expected 1", bus.dec_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.dec_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL mid_async: got dec_valid=%b req_valid=%b expected 0,0",
                               bus.dec_valid, bus.imem_req_valid);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        obs_pc.delete();
        obs_insn.delete();
        checks++;
        if (bus.imem_req_addr !== 64'h0) begin
            errors++; $display("FAIL mid_restart_addr: got %h expected 0", bus.imem_req_addr);
        end
        bus.dec_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (obs_pc.size() < 2 || obs_pc[0] !== 64'h0 || obs_pc[1] !== 64'h4) begin
            errors++; $display("FAIL mid_restart_seq: got %0d entries first=%h expected 0,4",
                               obs_pc.size(), (obs_pc.size() > 0) ? obs_pc[0] : 64'hX);
        end
    endtask

    // Unaligned target near the top of the address space wraps to zero.
    task automatic test_wrap();
        logic [63:0] exp_pc [3];
        exp_pc = '{64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFE, 64'h2};
        do_reset(1, 1'b1);
        repeat (3) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFA;
        obs_pc.delete();
        obs_insn.delete();
        tick();
        bus.redirect_valid = 1'b0;
        repeat (8) tick();
        checks++;
        if (obs_pc.size() < 3) begin
            errors++; $display("FAIL wrap_count: got %0d expected >=3", obs_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_pc[i] !== exp_pc[i] || obs_insn[i] !== mem_word(exp_pc[i])) begin
                    errors++;
                    $display("FAIL wrap%0d: got pc=%h insn=%h expected pc=%h insn=%h",
                             i, obs_pc[i], obs_insn[i], exp_pc[i], mem_word(exp_pc[i]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_latency();
        test_redirect_collision();
        test_back_to_back_redirect();
        test_reset_midstream();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front end of the pipelined ARMv8 core; sits directly upstream of the instruction decoder.
- Generates the PC and issues word fetches to instruction memory over a valid/ready request channel.
- Accepts in-order responses into a small instruction queue and presents {pc, instruction} to decode with valid/ready.
- Honours branch redirects from execute: flushes the queue and discards in-flight responses.

Parameters:
DEPTH, 4, instruction queue entries (power of two, >=2)
MAX_OUTSTANDING, 2, max imem requests issued but not yet answered (>=1)
RESET_PC, 64'h0, first fetch address after reset

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request this cycle
imem_req_addr  out  64  byte address of fetched word
imem_rsp_valid  in  1  response valid, in request order, no backpressure
imem_rsp_data  in  32  fetched instruction
redirect_valid  in  1  taken branch / unconditional branch from execute
redirect_pc  in  64  new fetch target
dec_valid  out  1  queue head valid
dec_ready  in  1  decoder consumes head
dec_pc  out  64  PC of head instruction
dec_instruction  out  32  head instruction

Behaviour:
- Clock and reset are fixed: one clock (clock); reset (reset_n) is asynchronous and active-low.
- Reset values:
  - fetch_pc = RESET_PC; rsp_pc = RESET_PC.
  - inflight = 0; drop = 0; queue empty.
  - imem_req_valid = 0; dec_valid = 0; dec_pc = 0; dec_instruction = 0.
- Live credits: live = inflight - drop.
- Request issue:
  - imem_req_valid = !redirect_valid && inflight < MAX_OUTSTANDING && (occupancy + live) < DEPTH.
  - imem_req_addr = fetch_pc.
  - Handshake (valid & ready): fetch_pc += 4, inflight += 1.
  - Request may be withdrawn, or its address changed, only on a redirect cycle.
- Response handling (imem_rsp_valid):
  - Always inflight -= 1.
  - If drop > 0: drop -= 1, data discarded.
  - Else: push {rsp_pc, imem_rsp_data} into the queue; rsp_pc += 4.
- Credit rule guarantees the queue never overflows. A push while full is a design error; bench asserts it never occurs.
- Decode side:
  - dec_valid = queue not empty; outputs are the registered head entry.
  - Pop on dec_valid & dec_ready.
  - Push-to-dec_valid latency is 1 cycle (no bypass).
  - Simultaneous push and pop is legal at any occupancy below full.
- Redirect (highest priority, same edge):
  - fetch_pc = redirect_pc; rsp_pc = redirect_pc.
  - Queue cleared; any pop and push this cycle ignored.
  - Response arriving this cycle is discarded.
  - drop = inflight_next, i.e. every request still unanswered after this cycle's events, including one accepted this cycle (its req_valid is forced 0, so none is accepted).
  - Fetch from redirect_pc is requested the next cycle.
  - Back-to-back redirects: the last one wins; drop is recomputed each time.
- Address arithmetic wraps modulo 2^64. No alignment checking; bits [1:0] are passed through.
- Reset mid-operation: all state clears immediately. Responses to pre-reset requests are the memory's responsibility (memory is reset by the same reset_n).
- Throughput: with 1-cycle imem and dec_ready held 1, one instruction per cycle in steady state.
- First dec_valid occurs 3 cycles after reset release with 1-cycle memory: request, response, queue.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W = 64, INSN_W = 32, PC_INCR = 4.
  - Struct fetch_entry_t {pc, instruction}.
- Sub-module fetch_queue: parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and count. The remaining credit/redirect logic stays in fetch_unit.

Test Plan:
- Reset release, 1-cycle imem, dec_ready=1 -> dec_pc sequence 0x0, 0x4, 0x8, 0xC, one per cycle from cycle 3; instructions match memory words.
- dec_ready=0 for 20 cycles -> exactly DEPTH=4 entries queued; imem_req_valid drops to 0; no overflow. Then dec_ready=1 -> 0x0..0xC delivered in order, fetch resumes at 0x10.
- 3-cycle imem latency, 2 requests in flight; redirect_valid with redirect_pc=0x400 -> both stale responses discarded, queue empty; next dec_pc is 0x400, then 0x404.
- Redirect on the same cycle as an imem response and a dec pop -> response dropped, pop ignored, dec_valid=0 the next cycle, then 0x400 follows.
- Two redirects on consecutive cycles (0x100, then 0x200) -> no instruction from 0x100 ever reaches decode; first dec_pc is 0x200.
- Assert reset_n low asynchronously mid-stream with queue half full -> dec_valid and imem_req_valid go 0 immediately; after release, fetch restarts at RESET_PC.
